// File: rtl/axis_capture_packetizer_if.sv
// AXI4-Stream bus bundle (tvalid/tready/tdata/tlast) used for the packetizer's output stream.
interface axis_capture_packetizer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_capture_packetizer.sv
// Decimates the unthrottled capture stream, stages one word so end-of-burst can carry tlast,
// and buffers words in a first-word-fall-through FIFO feeding a backpressured AXI4-Stream.
module axis_capture_packetizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_AW    = 10,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [7:0]                cfg_decim,
  input  logic [LEN_WIDTH-1:0]      cfg_pkt_len,
  input  logic                      clr_sts,
  axis_capture_packetizer_if.master m_axis,
  output logic                      sts_overflow,
  output logic [31:0]               sts_drop_cnt,
  output logic [FIFO_AW:0]          sts_fill
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FillFull = (FIFO_AW + 1)'(Depth);

  logic [7:0]            dec_cnt_q, dec_cnt_d;
  logic                  stage_vld_q, stage_vld_d;
  logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
  logic [LEN_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      fill_q, fill_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           drop_cnt_q, drop_cnt_d;

  // Each entry is {tlast, tdata}.
  logic [DATA_WIDTH:0]   mem_q [Depth];

  logic                  accept, flush, push_req, push_last, push_ok, pop, drop;
  logic                  out_vld;
  logic [DATA_WIDTH:0]   head;

  assign out_vld       = (fill_q != '0);
  assign head          = mem_q[rd_ptr_q];
  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_vld ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis.tlast  = out_vld & head[DATA_WIDTH];

  assign sts_overflow  = overflow_q;
  assign sts_drop_cnt  = drop_cnt_q;
  assign sts_fill      = fill_q;

  always_comb begin
    accept    = s_axis_tvalid && (dec_cnt_q == 8'd0);
    flush     = !s_axis_tvalid && stage_vld_q;
    push_req  = stage_vld_q && (accept || flush);
    push_last = flush ||
                ((cfg_pkt_len != '0) && (pkt_cnt_q == cfg_pkt_len - LEN_WIDTH'(1)));
    pop       = out_vld && m_axis.tready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    push_ok   = push_req && ((fill_q != FillFull) || pop);
    drop      = push_req && !push_ok;
  end

  always_comb begin
    dec_cnt_d = 8'd0;
    if (s_axis_tvalid && (dec_cnt_q < cfg_decim)) begin
      dec_cnt_d = dec_cnt_q + 8'd1;
    end

    stage_vld_d  = stage_vld_q;
    stage_data_d = stage_data_q;
    if (accept) begin
      stage_vld_d  = 1'b1;
      stage_data_d = s_axis_tdata;
    end else if (flush) begin
      stage_vld_d  = 1'b0;
    end

    // Framing counts delivered words only; dropped words leave it untouched.
    pkt_cnt_d = pkt_cnt_q;
    if (push_ok) begin
      pkt_cnt_d = push_last ? '0 : pkt_cnt_q + LEN_WIDTH'(1);
    end

    wr_ptr_d = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;

    fill_d = fill_q;
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + (FIFO_AW + 1)'(1);
      2'b01:   fill_d = fill_q - (FIFO_AW + 1)'(1);
      default: fill_d = fill_q;
    endcase

    // A drop coinciding with a clear counts as the first drop after the clear.
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_sts) begin
        drop_cnt_d = 32'd1;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 32'd1;
      end
    end else if (clr_sts) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      dec_cnt_q    <= '0;
      stage_vld_q  <= 1'b0;
      stage_data_q <= '0;
      pkt_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      dec_cnt_q    <= dec_cnt_d;
      stage_vld_q  <= stage_vld_d;
      stage_data_q <= stage_data_d;
      pkt_cnt_q    <= pkt_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage is not reset; occupancy gates what reaches the output.
  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {push_last, stage_data_q};
    end
  end

endmodule

// File: tb/tb_axis_capture_packetizer.sv
// Self-checking bench for axis_capture_packetizer: directed scenarios plus randomized bursts
// compared cycle by cycle against a queue-based reference model.
module tb_axis_capture_packetizer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned LW    = 16;
  localparam int unsigned Depth = 1 << AW;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic [7:0]    cfg_decim;
  logic [LW-1:0] cfg_pkt_len;
  logic          clr_sts;
  logic          sts_overflow;
  logic [31:0]   sts_drop_cnt;
  logic [AW:0]   sts_fill;

  axis_capture_packetizer_if #(.DATA_WIDTH(DW)) m_if ();

  axis_capture_packetizer #(
    .DATA_WIDTH (DW),
    .FIFO_AW    (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .cfg_decim     (cfg_decim),
    .cfg_pkt_len   (cfg_pkt_len),
    .clr_sts       (clr_sts),
    .m_axis        (m_if.master),
    .sts_overflow  (sts_overflow),
    .sts_drop_cnt  (sts_drop_cnt),
    .sts_fill      (sts_fill)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  // Words accepted by the downstream side, {tlast, tdata}.
  logic [DW:0] obs[$];
  always @(posedge aclk) begin
    if (!areset && m_if.tvalid && m_if.tready) obs.push_back({m_if.tlast, m_if.tdata});
  end

  // Reference model: a queue for the FIFO plus the spec's acceptance/framing/drop rules.
  logic [DW:0]   mq[$];
  bit            m_stage_v;
  logic [DW-1:0] m_stage_d;
  int            m_idx;
  int            m_pkt;
  logic [31:0]   m_drop;
  bit            m_ovf;

  task automatic model_reset();
    mq.delete();
    m_stage_v = 0;
    m_stage_d = '0;
    m_idx     = 0;
    m_pkt     = 0;
    m_drop    = '0;
    m_ovf     = 0;
  endtask

  task automatic model_step();
    bit pop, acc, flush, req, last, ok;
    pop   = (mq.size() != 0) && m_if.tready;
    acc   = s_axis_tvalid && ((m_idx % (int'(cfg_decim) + 1)) == 0);
    flush = !s_axis_tvalid && m_stage_v;
    req   = m_stage_v && (acc || flush);
    last  = flush || ((cfg_pkt_len != 0) && (m_pkt == int'(cfg_pkt_len) - 1));
    ok    = req && ((mq.size() < Depth) || pop);
    if (pop) void'(mq.pop_front());
    if (ok) begin
      mq.push_back({last, m_stage_d});
      m_pkt = last ? 0 : (m_pkt + 1) % 65536;
    end
    if (req && !ok) begin
      m_ovf = 1;
      if (clr_sts) m_drop = 32'd1;
      else if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
    end else if (clr_sts) begin
      m_ovf  = 0;
      m_drop = '0;
    end
    m_idx = s_axis_tvalid ? m_idx + 1 : 0;
    if (acc) begin
      m_stage_v = 1;
      m_stage_d = s_axis_tdata;
    end else if (flush) begin
      m_stage_v = 0;
    end
  endtask

  task automatic tick();
    if (areset) model_reset();
    else model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || m_if.tlast !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: got vld=%b data=%h last=%b want 0/0/0",
               m_if.tvalid, m_if.tdata, m_if.tlast);
    end
    n_cmp++;
    if (sts_fill !== '0 || sts_drop_cnt !== '0 || sts_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sts: got fill=%0d drop=%0d ovf=%b want 0/0/0",
               sts_fill, sts_drop_cnt, sts_overflow);
    end
    tick();
    tick();
    areset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic_burst();
    cfg_decim = 8'd0; cfg_pkt_len = '0; m_if.tready = 1'b1; obs.delete();
    drive(1'b1, 32'd1);
    n_cmp++;
    if (m_if.tvalid !== 1'b0) begin
      n_err++; $display("FAIL basic_lat_early: got vld=%b want 0", m_if.tvalid);
    end
    drive(1'b1, 32'd2);
    n_cmp++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd1) begin
      n_err++; $display("FAIL basic_lat: got vld=%b data=%h want 1/1", m_if.tvalid, m_if.tdata);
    end
    for (int i = 3; i <= 5; i++) drive(1'b1, DW'(i));
    idle(6);
    n_cmp++;
    if (obs.size() != 5) begin
      n_err++; $display("FAIL basic_count: got %0d want 5", obs.size());
    end
    for (int i = 0; i < 5; i++) begin
      logic [DW:0] exp, got;
      exp = {(i == 4), DW'(i + 1)};
      got = (i < obs.size()) ? obs[i] : '1;
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL basic_w%0d: got %h want %h", i, got, exp);
      end
    end
    n_cmp++;
    if (sts_drop_cnt !== '0) begin
      n_err++; $display("FAIL basic_drop: got %0d want 0", sts_drop_cnt);
    end
  endtask

  task automatic test_length_framing();
    cfg_pkt_len = LW'(4); obs.delete();
    for (int i = 1; i <= 10; i++) drive(1'b1, DW'(i));
    idle(3);
    for (int i = 11; i <= 13; i++) drive(1'b1, DW'(i));
    idle(6);
    n_cmp++;
    if (obs.size() != 13) begin
      n_err++; $display("FAIL frame_count: got %0d want 13", obs.size());
    end
    for (int i = 0; i < 13; i++) begin
      logic [DW:0] exp, got;
      exp = {(i == 3 || i == 7 || i == 9 || i == 12), DW'(i + 1)};
      got = (i < obs.size()) ? obs[i] : '1;
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL frame_w%0d: got %h want %h", i, got, exp);
      end
    end
    cfg_pkt_len = '0;
  endtask

  task automatic test_decimation();
    logic [DW:0] exp[4];
    cfg_decim = 8'd2; obs.delete();
    for (int i = 0; i <= 8; i++) drive(1'b1, DW'(i));
    idle(3);
    drive(1'b1, 32'd10);
    drive(1'b1, 32'd11);
    idle(6);
    exp[0] = {1'b0, 32'd0}; exp[1] = {1'b0, 32'd3};
    exp[2] = {1'b1, 32'd6}; exp[3] = {1'b1, 32'd10};
    n_cmp++;
    if (obs.size() != 4) begin
      n_err++; $display("FAIL decim_count: got %0d want 4", obs.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [DW:0] got;
      got = (i < obs.size()) ? obs[i] : '1;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++; $display("FAIL decim_w%0d: got %h want %h", i, got, exp[i]);
      end
    end
    cfg_decim = 8'd0;
  endtask

  task automatic test_overflow();
    m_if.tready = 1'b0; obs.delete();
    for (int i = 0; i < 20; i++) drive(1'b1, DW'(200 + i));
    idle(2);
    n_cmp++;
    if (sts_fill !== (AW + 1)'(16) || sts_drop_cnt !== 32'd4 || sts_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sts: got fill=%0d drop=%0d ovf=%b want 16/4/1",
               sts_fill, sts_drop_cnt, sts_overflow);
    end
    m_if.tready = 1'b1;
    idle(20);
    n_cmp++;
    if (obs.size() != 16) begin
      n_err++; $display("FAIL ovf_count: got %0d want 16", obs.size());
    end
    for (int i = 0; i < 16; i++) begin
      logic [DW:0] exp, got;
      exp = {1'b0, DW'(200 + i)};
      got = (i < obs.size()) ? obs[i] : '1;
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL ovf_w%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_full_pop_clr();
    clr_sts = 1'b1;
    idle(1);
    clr_sts = 1'b0;
    n_cmp++;
    if (sts_drop_cnt !== '0 || sts_overflow !== 1'b0) begin
      n_err++; $display("FAIL clr_sts: got drop=%0d ovf=%b want 0/0", sts_drop_cnt, sts_overflow);
    end
    m_if.tready = 1'b0; obs.delete();
    for (int i = 0; i < 17; i++) drive(1'b1, DW'(300 + i));
    n_cmp++;
    if (sts_fill !== (AW + 1)'(16)) begin
      n_err++; $display("FAIL full_fill: got %0d want 16", sts_fill);
    end
    m_if.tready = 1'b1;
    for (int i = 17; i < 27; i++) begin
      drive(1'b1, DW'(300 + i));
      n_cmp++;
      if (sts_fill !== (AW + 1)'(16) || sts_drop_cnt !== '0) begin
        n_err++;
        $display("FAIL full_pop_c%0d: got fill=%0d drop=%0d want 16/0", i, sts_fill, sts_drop_cnt);
      end
    end
    idle(20);
    n_cmp++;
    if (obs.size() != 27) begin
      n_err++; $display("FAIL full_count: got %0d want 27", obs.size());
    end
    for (int i = 0; i < 27; i++) begin
      logic [DW:0] exp, got;
      exp = {(i == 26), DW'(300 + i)};
      got = (i < obs.size()) ? obs[i] : '1;
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL full_w%0d: got %h want %h", i, got, exp);
      end
    end
    m_if.tready = 1'b0;
    for (int i = 0; i < 19; i++) drive(1'b1, DW'(400 + i));
    n_cmp++;
    if (sts_drop_cnt !== 32'd2) begin
      n_err++; $display("FAIL pre_clr_drop: got %0d want 2", sts_drop_cnt);
    end
    clr_sts = 1'b1;
    idle(1);
    clr_sts = 1'b0;
    n_cmp++;
    if (sts_drop_cnt !== 32'd1 || sts_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clr_vs_drop: got drop=%0d ovf=%b want 1/1", sts_drop_cnt, sts_overflow);
    end
    m_if.tready = 1'b1;
    idle(20);
  endtask

  task automatic test_reset_mid();
    m_if.tready = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, DW'(500 + i));
    n_cmp++;
    if (sts_fill !== (AW + 1)'(7)) begin
      n_err++; $display("FAIL mid_pre_fill: got %0d want 7", sts_fill);
    end
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();
    n_cmp++;
    if (m_if.tvalid !== 1'b0 || sts_fill !== '0 || sts_drop_cnt !== '0 || sts_overflow !== 1'b0)
    begin
      n_err++;
      $display("FAIL mid_reset: got vld=%b fill=%0d drop=%0d ovf=%b want 0/0/0/0",
               m_if.tvalid, sts_fill, sts_drop_cnt, sts_overflow);
    end
    areset = 1'b0;
    m_if.tready = 1'b1; obs.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(600 + i));
    idle(6);
    n_cmp++;
    if (obs.size() != 3) begin
      n_err++; $display("FAIL mid_post_count: got %0d want 3", obs.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [DW:0] exp, got;
      exp = {(i == 2), DW'(600 + i)};
      got = (i < obs.size()) ? obs[i] : '1;
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL mid_post_w%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_random();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int b = 0; b < 30; b++) begin
      int len, gap, rdy_pct;
      cfg_decim   = 8'($urandom_range(0, 3));
      cfg_pkt_len = LW'($urandom_range(0, 6));
      rdy_pct     = $urandom_range(10, 100);
      gap         = $urandom_range(1, 6);
      len         = $urandom_range(1, 40);
      for (int c = 0; c < gap + len; c++) begin
        s_axis_tvalid = (c >= gap);
        s_axis_tdata  = $urandom();
        m_if.tready   = ($urandom_range(1, 100) <= rdy_pct);
        clr_sts       = ($urandom_range(0, 19) == 0);
        tick();
        n_cmp++;
        if (m_if.tvalid !== (mq.size() != 0) || sts_fill !== (AW + 1)'(mq.size()) ||
            sts_drop_cnt !== m_drop || sts_overflow !== m_ovf) begin
          n_err++;
          $display("FAIL rand_b%0d_c%0d: got vld=%b fill=%0d drop=%0d ovf=%b want %b/%0d/%0d/%b",
                   b, c, m_if.tvalid, sts_fill, sts_drop_cnt, sts_overflow,
                   (mq.size() != 0), mq.size(), m_drop, m_ovf);
        end
        if (mq.size() != 0) begin
          n_cmp++;
          if ({m_if.tlast, m_if.tdata} !== mq[0]) begin
            n_err++;
            $display("FAIL rand_head_b%0d_c%0d: got %h want %h",
                     b, c, {m_if.tlast, m_if.tdata}, mq[0]);
          end
        end
      end
    end
    clr_sts = 1'b0;
  endtask

  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    cfg_decim     = 8'd0;
    cfg_pkt_len   = '0;
    clr_sts       = 1'b0;
    m_if.tready   = 1'b0;
    areset        = 1'b0;
    model_reset();
    #2 areset = 1'b1;
    test_reset();
    test_basic_burst();
    test_length_framing();
    test_decimation();
    test_overflow();
    test_full_pop_clr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
